// File: rtl/seq_sign_shifter.sv
// Multi-cycle shifter: SLL, SRL, SRA and sign-preserving SLL, one bit per clock.
// Optional SIGN_SHIFT_OVF_EN adds a sticky ovf flag for the sign-preserving shift.
module seq_sign_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SIGN_SHIFT_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_SLLS = 2'b11;

    logic [1:0]       state;
    logic [1:0]       mode;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] shifted;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = data;

    always_comb begin
        shifted = data;
        case (mode)
            MODE_SLL:  shifted = {data[WIDTH-2:0], 1'b0};
            MODE_SRL:  shifted = {1'b0, data[WIDTH-1:1]};
            MODE_SRA:  shifted = {data[WIDTH-1], data[WIDTH-1:1]};
            // Sign held in place; bit W-2 falls off the top of the magnitude.
            MODE_SLLS: shifted = {data[WIDTH-1], data[WIDTH-3:0], 1'b0};
            default:   shifted = data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode  <= MODE_SLL;
            cnt   <= '0;
            data  <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in_data;
                        mode  <= in_mode;
                        cnt   <= in_shamt;
                        state <= (in_shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data <= shifted;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SIGN_SHIFT_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (flush) begin
            ovf <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && mode == MODE_SLLS) begin
            if (data[WIDTH-2] != data[WIDTH-1]) ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_sign_shifter.sv
// Directed bench for seq_sign_shifter: 32-bit and 4-bit instances side by side.
`timescale 1ns/1ps
module tb_seq_sign_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        use4;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        in_valid32, in_ready32, out_valid32;
    logic [31:0] out_data32;
    logic        in_valid4, in_ready4, out_valid4;
    logic [3:0]  out_data4;
`ifdef SIGN_SHIFT_OVF_EN
    logic        ovf32, ovf4;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign in_valid32 = in_valid & ~use4;
    assign in_valid4  = in_valid & use4;

    seq_sign_shifter #(.WIDTH(32), .SHW(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid32), .out_ready(out_ready),
`ifdef SIGN_SHIFT_OVF_EN
        .ovf(ovf32),
`endif
        .out_data(out_data32)
    );

    seq_sign_shifter #(.WIDTH(4), .SHW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data[3:0]), .in_shamt(in_shamt[1:0]), .in_mode(in_mode),
        .out_valid(out_valid4), .out_ready(out_ready),
`ifdef SIGN_SHIFT_OVF_EN
        .ovf(ovf4),
`endif
        .out_data(out_data4)
    );

    typedef struct {
        bit          w4;
        logic [1:0]  mode;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          lat;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] cur_data();
        return use4 ? {28'd0, out_data4} : out_data32;
    endfunction

    function automatic logic cur_valid();
        return use4 ? out_valid4 : out_valid32;
    endfunction

    function automatic logic cur_ready();
        return use4 ? in_ready4 : in_ready32;
    endfunction

    task automatic run_op(input string name, input bit w4, input logic [1:0] m,
                          input logic [31:0] d, input logic [4:0] sh,
                          input logic [31:0] exp, input int lat, input bit eovf);
        int n;
        @(negedge clk);
        use4 = w4;
        check({name, " idle"}, 32'(cur_ready()), 32'd1);
        in_valid = 1'b1; in_mode = m; in_data = d; in_shamt = sh;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = ~m; in_shamt = ~sh;
        n = 0;
        while (!cur_valid() && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " data"}, cur_data(), exp);
`ifdef SIGN_SHIFT_OVF_EN
        check({name, " ovf"}, 32'(use4 ? ovf4 : ovf32), 32'(eovf));
`else
        if (eovf) n = n;
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " drain"}, {30'd0, cur_ready(), cur_valid()}, 32'd2);
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 2'b11, 32'hC,         5'd1,  32'h8,         1,  1'b0};
        vecs[1]  = '{1'b1, 2'b11, 32'h6,         5'd2,  32'h0,         2,  1'b1};
        vecs[2]  = '{1'b0, 2'b10, 32'h8000_0010, 5'd4,  32'hF800_0001, 4,  1'b0};
        vecs[3]  = '{1'b0, 2'b01, 32'h8000_0010, 5'd4,  32'h0800_0001, 4,  1'b0};
        vecs[4]  = '{1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 31, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 32'h0000_0001, 5'd31, 32'h0000_0000, 31, 1'b1};
        vecs[6]  = '{1'b0, 2'b11, 32'hFFFF_FFF0, 5'd4,  32'hFFFF_FF00, 4,  1'b0};
        vecs[7]  = '{1'b0, 2'b11, 32'h8000_0003, 5'd4,  32'h8000_0030, 4,  1'b1};
        vecs[8]  = '{1'b0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31, 1'b0};
        vecs[9]  = '{1'b0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 31, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 32'h8,         5'd3,  32'hF,         3,  1'b0};
        vecs[11] = '{1'b1, 2'b00, 32'h3,         5'd3,  32'h8,         3,  1'b0};
        vecs[12] = '{1'b1, 2'b01, 32'h8,         5'd5,  32'h4,         1,  1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; use4 = 1'b0;
        in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b0;
        #23;
        check("reset ready32", 32'(in_ready32), 32'd1);
        check("reset valid32", 32'(out_valid32), 32'd0);
        check("reset data32", out_data32, 32'd0);
        check("reset ready4", 32'(in_ready4), 32'd1);
`ifdef SIGN_SHIFT_OVF_EN
        check("reset ovf32", 32'(ovf32), 32'd0);
`endif
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].w4, vecs[i].mode,
                   vecs[i].data, vecs[i].shamt, vecs[i].exp,
                   vecs[i].lat, vecs[i].exp_ovf);

        // shamt=0 result held under back-pressure, no accept while in DONE
        @(negedge clk);
        use4 = 1'b0; in_valid = 1'b1; in_mode = 2'b00;
        in_data = 32'h1234_5678; in_shamt = 5'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sh0 valid", 32'(out_valid32), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0 ||
                out_data32 !== 32'h1234_5678) seen = 1'b1;
        end
        check("hold stable", 32'(seen), 32'd0);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF; in_shamt = 5'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("done no accept", {30'd0, in_ready32, out_valid32}, 32'd2);
        @(posedge clk); #1;
        check("done no accept2", 32'(out_valid32), 32'd0);

        // flush on the 10th SHIFT cycle of a 31-step shift
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b00; in_data = 32'h1; in_shamt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre-flush busy", 32'(in_ready32), 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_shamt = 5'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush ready", {30'd0, in_ready32, out_valid32}, 32'd2);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid32) seen = 1'b1;
        end
        check("flush no valid", 32'(seen), 32'd0);
        run_op("post-flush", 1'b0, 2'b00, 32'h1, 5'd1, 32'h2, 1, 1'b0);

        // flush while DONE with out_ready: result discarded, data kept
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b01; in_data = 32'h5; in_shamt = 5'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        held = out_data32;
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flushdone state", {30'd0, in_ready32, out_valid32}, 32'd2);
        check("flushdone data", out_data32, 32'h5);
        check("flushdone held", out_data32, held);

        // asynchronous reset mid-SHIFT
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b00; in_data = 32'h3; in_shamt = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst state", {30'd0, in_ready32, out_valid32}, 32'd2);
        check("arst data", out_data32, 32'd0);
        #2 rst_n = 1'b1;
        run_op("post-reset", 1'b0, 2'b00, 32'h3, 5'd2, 32'hC, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
